// File: rtl/demux_1x2_buf_pkg.sv
// rtl/demux_1x2_buf_pkg.sv - shared constants and slot state type for the buffered 1-to-2 demux
package demux_1x2_buf_pkg;

  localparam logic SEL_OUT1      = 1'b1;
  localparam logic SEL_OUT2      = 1'b0;
  localparam int   WIDTH_DATA    = 16;
  localparam int   CNT_W_DEFAULT = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output slot with load/drain handshake and delivered-word counter
module demux_slot
  import demux_1x2_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DATA,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  slot_state_t state;

  assign valid = (state == SLOT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      data  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state <= SLOT_FULL;
            data  <= load_data;
          end
        end
        SLOT_FULL: begin
          // A load in the drain cycle replaces the word and keeps the slot full.
          if (load) begin
            data <= load_data;
          end else if (ready) begin
            state <= SLOT_EMPTY;
          end
          if (ready) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/demux_1x2_buf.sv
// rtl/demux_1x2_buf.sv - buffered 1-to-2 demux steering one valid/ready input into two output slots
module demux_1x2_buf
  import demux_1x2_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DATA,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic out1_free;
  logic out2_free;
  logic accept;
  logic load1;
  logic load2;

  // Only the addressed slot gates the input; the other slot never bypasses it.
  assign out1_free = !out1_valid || out1_ready;
  assign out2_free = !out2_valid || out2_ready;
  assign in_ready  = (in_sel == SEL_OUT1) ? out1_free : out2_free;
  assign accept    = in_valid && in_ready;
  assign load1     = accept && (in_sel == SEL_OUT1);
  assign load2     = accept && (in_sel == SEL_OUT2);

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .valid     (out1_valid),
    .ready     (out1_ready),
    .data      (out1_data),
    .cnt       (cnt1)
  );

  demux_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot2 (
    .clk       (clk),
    .rst       (rst),
    .load      (load2),
    .load_data (in_data),
    .valid     (out2_valid),
    .ready     (out2_ready),
    .data      (out2_data),
    .cnt       (cnt2)
  );

endmodule

// File: tb/tb_demux_1x2_buf.sv
// tb/tb_demux_1x2_buf.sv - self-checking bench for demux_1x2_buf
module tb_demux_1x2_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel = 1'b1;
  logic [15:0] in_data = '0;
  logic        out1_valid;
  logic        out1_ready = 1'b0;
  logic [15:0] out1_data;
  logic        out2_valid;
  logic        out2_ready = 1'b0;
  logic [15:0] out2_data;
  logic [7:0]  cnt1;
  logic [7:0]  cnt2;

  always #5 clk = ~clk;

  demux_1x2_buf #(.WIDTH(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] exp1_q[$];
  logic [15:0] exp2_q[$];

  logic        mv1, mv2;
  logic [15:0] md1, md2;
  logic [7:0]  mc1, mc2;
  logic        last_acc;

  typedef struct packed {
    logic        iv;
    logic        sel;
    logic [15:0] d;
    logic        r1;
    logic        r2;
    logic        rdy;
    logic        v1;
    logic [15:0] d1;
    logic        v2;
    logic [15:0] d2;
    logic [7:0]  c1;
    logic [7:0]  c2;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mv1 = 1'b0; mv2 = 1'b0;
    md1 = '0;   md2 = '0;
    mc1 = '0;   mc2 = '0;
    last_acc = 1'b0;
    exp1_q.delete();
    exp2_q.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    in_sel = 1'b1; in_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  // One clock: check current outputs against the model at the falling edge,
  // score handshakes, then advance the model across the rising edge.
  task automatic step();
    logic rdy, acc, hs1, hs2;
    @(negedge clk);
    rdy = in_sel ? (!mv1 || out1_ready) : (!mv2 || out2_ready);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out1_valid", 32'(out1_valid), 32'(mv1));
    chk("out2_valid", 32'(out2_valid), 32'(mv2));
    chk("out1_data", 32'(out1_data), 32'(md1));
    chk("out2_data", 32'(out2_data), 32'(md2));
    chk("cnt1", 32'(cnt1), 32'(mc1));
    chk("cnt2", 32'(cnt2), 32'(mc2));
    hs1 = mv1 && out1_ready;
    hs2 = mv2 && out2_ready;
    if (hs1) begin
      if (exp1_q.size() == 0) chk("sb1_underflow", 32'(1), 32'(0));
      else chk("sb1_data", 32'(out1_data), 32'(exp1_q.pop_front()));
    end
    if (hs2) begin
      if (exp2_q.size() == 0) chk("sb2_underflow", 32'(1), 32'(0));
      else chk("sb2_data", 32'(out2_data), 32'(exp2_q.pop_front()));
    end
    acc = in_valid && rdy;
    if (acc && in_sel) exp1_q.push_back(in_data);
    if (acc && !in_sel) exp2_q.push_back(in_data);
    @(posedge clk);
    if (hs1) mc1 = mc1 + 8'd1;
    if (hs2) mc2 = mc2 + 8'd1;
    if (acc && in_sel) begin mv1 = 1'b1; md1 = in_data; end
    else if (hs1) mv1 = 1'b0;
    if (acc && !in_sel) begin mv2 = 1'b1; md2 = in_data; end
    else if (hs2) mv2 = 1'b0;
    last_acc = acc;
    #1;
  endtask

  initial begin
    //          iv    sel   d        r1    r2    rdy   v1    d1       v2    d2       c1    c2
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0, 16'h0000, 8'd0, 8'd0};
    vecs[2] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000, 8'd0, 8'd0};
    vecs[3] = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 8'd1, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 16'h5555, 8'd1, 8'd0};
    vecs[5] = '{1'b1, 1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h5555, 8'd1, 8'd1};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h5555, 8'd2, 8'd1};
    vecs[7] = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 16'h0001, 8'd2, 8'd1};
    vecs[8] = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 16'h0002, 8'd2, 8'd2};
    vecs[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0002, 8'd2, 8'd3};

    do_reset();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out1_valid", 32'(out1_valid), 32'(0));
    chk("rst_out2_valid", 32'(out2_valid), 32'(0));
    chk("rst_out1_data", 32'(out1_data), 32'(0));
    chk("rst_out2_data", 32'(out2_data), 32'(0));
    chk("rst_cnt1", 32'(cnt1), 32'(0));
    chk("rst_cnt2", 32'(cnt2), 32'(0));

    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].iv; in_sel = vecs[i].sel; in_data = vecs[i].d;
      out1_ready = vecs[i].r1; out2_ready = vecs[i].r2;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      step();
      chk($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].v1));
      chk($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(vecs[i].d1));
      chk($sformatf("vec%0d_out2_valid", i), 32'(out2_valid), 32'(vecs[i].v2));
      chk($sformatf("vec%0d_out2_data", i), 32'(out2_data), 32'(vecs[i].d2));
      chk($sformatf("vec%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].c1));
      chk($sformatf("vec%0d_cnt2", i), 32'(cnt2), 32'(vecs[i].c2));
    end

    // Streaming with alternating select and both consumers always ready.
    do_reset();
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_sel = (i % 2 == 0); in_data = 16'(i);
      step();
      if (i % 2 == 0) begin
        chk("stream_out1_valid", 32'(out1_valid), 32'(1));
        chk("stream_out1_data", 32'(out1_data), 32'(i));
      end else begin
        chk("stream_out2_valid", 32'(out2_valid), 32'(1));
        chk("stream_out2_data", 32'(out2_data), 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    chk("stream_cnt1", 32'(cnt1), 32'(5));
    chk("stream_cnt2", 32'(cnt2), 32'(5));
    chk("stream_sb_empty", 32'(exp1_q.size() + exp2_q.size()), 32'(0));

    // Counter wrap on output 1.
    do_reset();
    out1_ready = 1'b1; out2_ready = 1'b0; in_sel = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      in_valid = (i < 256); in_data = 16'(i * 3);
      step();
      if (i == 255) chk("wrap_cnt1_255", 32'(cnt1), 32'(255));
    end
    chk("wrap_cnt1_0", 32'(cnt1), 32'(0));
    chk("wrap_cnt2_0", 32'(cnt2), 32'(0));

    // Constrained-random traffic; producer holds its offer until accepted.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel = 1'($urandom_range(0, 1));
        in_data = 16'($urandom);
      end
      out1_ready = ($urandom_range(0, 2) != 0);
      out2_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Asynchronous reset while both slots hold words and consumers are ready.
    do_reset();
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hAAAA;
    step();
    in_sel = 1'b0; in_data = 16'hBBBB; out1_ready = 1'b1;
    step();
    in_sel = 1'b1; in_data = 16'hCCCC; out1_ready = 1'b0;
    step();
    chk("pre_rst_both_full", 32'({out1_valid, out2_valid}), 32'(2'b11));
    chk("pre_rst_cnt1", 32'(cnt1), 32'(1));
    in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_out1_valid", 32'(out1_valid), 32'(0));
    chk("arst_out2_valid", 32'(out2_valid), 32'(0));
    chk("arst_out1_data", 32'(out1_data), 32'(0));
    chk("arst_out2_data", 32'(out2_data), 32'(0));
    chk("arst_cnt1", 32'(cnt1), 32'(0));
    chk("arst_cnt2", 32'(cnt2), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    step();
    chk("post_rst_cnt1", 32'(cnt1), 32'(0));
    chk("post_rst_cnt2", 32'(cnt2), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
